// File: rtl/wave_capture_ctrl.sv
// Capture sequencer for one wave channel: decimates ADC samples, finds the trigger,
// writes a pre/post-trigger frame into the back bank and swaps banks when not held.
module wave_capture_ctrl #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 12,
  parameter int PRETRIG      = 64,
  parameter int AUTO_TIMEOUT = 2048
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sampleValid,
  input  logic [DATA_W-1:0] sampleData,
  input  logic [5:0]        sampleAdjust,
  input  logic              hold,
  input  logic [DATA_W-1:0] triggerLevel,
  input  logic              triggerFalling,
  input  logic              autoEn,
  output logic              wrEn,
  output logic [ADDR_W:0]   wrAddr,
  output logic [DATA_W-1:0] wrData,
  output logic              displayBank,
  output logic [ADDR_W-1:0] displayStart,
  output logic              frameReady,
  output logic              autoTrig,
  output logic [2:0]        captureState
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int TO_W  = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRETRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(DEPTH - PRETRIG - 2);
  localparam logic [ADDR_W-1:0] PRETRIG_A = ADDR_W'(PRETRIG);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_SWAP  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        decCnt_q, decCnt_d, adj_q, adj_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, cnt_q, cnt_d, trigPtr_q, trigPtr_d;
  logic [TO_W-1:0]   toCnt_q, toCnt_d;
  logic [DATA_W-1:0] prev_q, prev_d, wrData_q, wrData_d;
  logic              prevOk_q, prevOk_d, autoFlag_q, autoFlag_d;
  logic              wrEn_q, wrEn_d, wb_q, wb_d, db_q, db_d;
  logic [ADDR_W:0]   wrAddr_q, wrAddr_d;
  logic [ADDR_W-1:0] dstart_q, dstart_d;
  logic              frameReady_q, frameReady_d, autoTrig_q, autoTrig_d;
  logic              active, accept, trigHit, timeout, enterPre;

  assign active  = (state_q == S_PRE) || (state_q == S_ARMED) || (state_q == S_POST);
  assign accept  = active && sampleValid && (decCnt_q == '0);
  assign trigHit = prevOk_q && (triggerFalling
                   ? (prev_q > triggerLevel) && (sampleData <= triggerLevel)
                   : (prev_q < triggerLevel) && (sampleData >= triggerLevel));
  assign timeout = autoEn && (toCnt_q == TO_LAST);

  always_comb begin
    state_d      = state_q;
    decCnt_d     = decCnt_q;
    adj_d        = adj_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    toCnt_d      = toCnt_q;
    prev_d       = prev_q;
    prevOk_d     = prevOk_q;
    trigPtr_d    = trigPtr_q;
    autoFlag_d   = autoFlag_q;
    wrEn_d       = 1'b0;
    wrAddr_d     = wrAddr_q;
    wrData_d     = wrData_q;
    wb_d         = wb_q;
    db_d         = db_q;
    dstart_d     = dstart_q;
    frameReady_d = 1'b0;
    autoTrig_d   = autoTrig_q;
    enterPre     = 1'b0;

    if (active && sampleValid)
      decCnt_d = (decCnt_q == '0) ? adj_q : decCnt_q - 6'd1;

    if (accept) begin
      wrEn_d   = 1'b1;
      wrAddr_d = {wb_q, ptr_q};
      wrData_d = sampleData;
      ptr_d    = ptr_q + 1'b1;
      prev_d   = sampleData;
      prevOk_d = 1'b1;
    end

    case (state_q)
      S_IDLE: if (!hold && ptr_q == '0 && decCnt_q == '0) enterPre = 1'b1;
      S_PRE: if (accept) begin
        if (cnt_q == PRE_LAST) begin
          state_d = S_ARMED;
          toCnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ARMED: if (accept) begin
        if (toCnt_q != TO_LAST) toCnt_d = toCnt_q + 1'b1;
        // trigger sample becomes post sample 0, so the POST count restarts here
        if (trigHit || timeout) begin
          state_d    = S_POST;
          trigPtr_d  = ptr_q;
          autoFlag_d = !trigHit;
          cnt_d      = '0;
        end
      end
      S_POST: if (accept) begin
        if (cnt_q == POST_LAST) state_d = S_SWAP;
        else                    cnt_d   = cnt_q + 1'b1;
      end
      S_SWAP: begin
        ptr_d    = '0;
        decCnt_d = '0;
        if (!hold) begin
          db_d         = wb_q;
          wb_d         = ~wb_q;
          dstart_d     = trigPtr_q - PRETRIG_A;
          autoTrig_d   = autoFlag_q;
          frameReady_d = 1'b1;
          enterPre     = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enterPre) begin
      state_d  = S_PRE;
      adj_d    = sampleAdjust;
      prevOk_d = 1'b0;
      cnt_d    = '0;
      ptr_d    = '0;
      decCnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      decCnt_q     <= '0;
      adj_q        <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      toCnt_q      <= '0;
      prev_q       <= '0;
      prevOk_q     <= 1'b0;
      trigPtr_q    <= '0;
      autoFlag_q   <= 1'b0;
      wrEn_q       <= 1'b0;
      wrAddr_q     <= '0;
      wrData_q     <= '0;
      wb_q         <= 1'b0;
      db_q         <= 1'b1;
      dstart_q     <= '0;
      frameReady_q <= 1'b0;
      autoTrig_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      decCnt_q     <= decCnt_d;
      adj_q        <= adj_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      toCnt_q      <= toCnt_d;
      prev_q       <= prev_d;
      prevOk_q     <= prevOk_d;
      trigPtr_q    <= trigPtr_d;
      autoFlag_q   <= autoFlag_d;
      wrEn_q       <= wrEn_d;
      wrAddr_q     <= wrAddr_d;
      wrData_q     <= wrData_d;
      wb_q         <= wb_d;
      db_q         <= db_d;
      dstart_q     <= dstart_d;
      frameReady_q <= frameReady_d;
      autoTrig_q   <= autoTrig_d;
    end
  end

  assign wrEn         = wrEn_q;
  assign wrAddr       = wrAddr_q;
  assign wrData       = wrData_q;
  assign displayBank  = db_q;
  assign displayStart = dstart_q;
  assign frameReady   = frameReady_q;
  assign autoTrig     = autoTrig_q;
  assign captureState = state_q;
endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Directed bench for wave_capture_ctrl with a 16-entry bank, 4 pre-trigger samples, timeout 32.
module tb_wave_capture_ctrl;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 12;

  logic              clock = 1'b0;
  logic              reset, sampleValid, hold, triggerFalling, autoEn;
  logic [DATA_W-1:0] sampleData, triggerLevel;
  logic [5:0]        sampleAdjust;
  logic              wrEn, displayBank, frameReady, autoTrig;
  logic [ADDR_W:0]   wrAddr;
  logic [DATA_W-1:0] wrData;
  logic [ADDR_W-1:0] displayStart;
  logic [2:0]        captureState;

  int checks = 0;
  int failures = 0;

  wave_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PRETRIG(4), .AUTO_TIMEOUT(32)) dut (
    .clock(clock), .reset(reset), .sampleValid(sampleValid), .sampleData(sampleData),
    .sampleAdjust(sampleAdjust), .hold(hold), .triggerLevel(triggerLevel),
    .triggerFalling(triggerFalling), .autoEn(autoEn), .wrEn(wrEn), .wrAddr(wrAddr),
    .wrData(wrData), .displayBank(displayBank), .displayStart(displayStart),
    .frameReady(frameReady), .autoTrig(autoTrig), .captureState(captureState)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        vld;
    logic [11:0] data;
    logic [2:0]  st;
    logic        we;
    logic [4:0]  addr;
    logic [11:0] wd;
    logic        fr;
    logic        db;
    logic [3:0]  ds;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(logic v, int d, int st, logic we, int a, int wd,
                              logic fr, logic db, int ds);
    vec_t r;
    r.vld = v; r.data = 12'(d); r.st = 3'(st); r.we = we; r.addr = 5'(a);
    r.wd = 12'(wd); r.fr = fr; r.db = db; r.ds = 4'(ds);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; sampleValid = 1'b0; sampleData = '0; sampleAdjust = '0; hold = 1'b0;
    triggerLevel = 12'd2000; triggerFalling = 1'b0; autoEn = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    int writes, postWrites, lastW, frCount;
    bit seenArmed, seenPost, done;

    // reset values
    do_reset();
    reset = 1'b1; tick();
    chk("rst.state", captureState, 0);
    chk("rst.wrEn", wrEn, 0);
    chk("rst.wrAddr", wrAddr, 0);
    chk("rst.wrData", wrData, 0);
    chk("rst.displayBank", displayBank, 1);
    chk("rst.displayStart", displayStart, 0);
    chk("rst.frameReady", frameReady, 0);
    chk("rst.autoTrig", autoTrig, 0);

    // table: falling trigger, 2000/2000 must not fire, 3000->1500 fires
    for (int i = 0; i < 4; i++) tbl[i] = mk(1, 2000, (i == 3) ? 2 : 1, 1, i, 2000, 0, 1, 0);
    tbl[4] = mk(1, 2000, 2, 1, 4, 2000, 0, 1, 0);
    tbl[5] = mk(1, 2000, 2, 1, 5, 2000, 0, 1, 0);
    tbl[6] = mk(0, 0,    2, 0, 5, 2000, 0, 1, 0);
    tbl[7] = mk(1, 3000, 2, 1, 6, 3000, 0, 1, 0);
    tbl[8] = mk(1, 1500, 3, 1, 7, 1500, 0, 1, 0);
    for (int k = 0; k < 11; k++)
      tbl[9+k] = mk(1, 1000, (k == 10) ? 4 : 3, 1, (8 + k) % 16, 1000, 0, 1, 0);
    tbl[20] = mk(1, 1000, 1, 0, 2,  1000, 1, 0, 3);
    tbl[21] = mk(1, 500,  1, 1, 16, 500,  0, 0, 3);

    do_reset();
    triggerFalling = 1'b1;
    tick();
    chk("tbl.enterPre", captureState, 1);
    for (int i = 0; i < 22; i++) begin
      sampleValid = tbl[i].vld; sampleData = tbl[i].data;
      tick();
      chk($sformatf("vec%0d.state", i), captureState, tbl[i].st);
      chk($sformatf("vec%0d.wrEn", i), wrEn, tbl[i].we);
      chk($sformatf("vec%0d.wrAddr", i), wrAddr, tbl[i].addr);
      chk($sformatf("vec%0d.wrData", i), wrData, tbl[i].wd);
      chk($sformatf("vec%0d.frameReady", i), frameReady, tbl[i].fr);
      chk($sformatf("vec%0d.displayBank", i), displayBank, tbl[i].db);
      chk($sformatf("vec%0d.displayStart", i), displayStart, tbl[i].ds);
    end
    chk("tbl.autoTrig", autoTrig, 0);

    // rising ramp, step 256
    do_reset(); tick();
    writes = 0; postWrites = 0; seenArmed = 0; seenPost = 0; done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      sampleValid = 1'b1; sampleData = 12'((k * 256) % 4096);
      tick();
      if (wrEn) writes++;
      if (captureState == 3'd2 && !seenArmed) begin
        seenArmed = 1; chk("ramp.writesToArmed", writes, 4);
      end
      if (captureState == 3'd3 && !seenPost) begin
        seenPost = 1;
        chk("ramp.trigData", wrData, 2048);
        chk("ramp.trigAddr", wrAddr, 8);
      end else if (seenPost && wrEn) postWrites++;
      if (frameReady) begin
        done = 1;
        chk("ramp.postWrites", postWrites, 11);
        chk("ramp.displayBank", displayBank, 0);
        chk("ramp.displayStart", displayStart, 4);
        chk("ramp.autoTrig", autoTrig, 0);
      end
    end
    if (!done) timeout_fail("ramp.frameReady");

    // auto-trigger on flat data
    do_reset(); autoEn = 1'b1; tick();
    writes = 0; done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      sampleValid = 1'b1; sampleData = 12'd100;
      tick();
      if (wrEn) writes++;
      if (frameReady) begin
        done = 1;
        chk("auto.writes", writes, 47);
        chk("auto.autoTrig", autoTrig, 1);
        chk("auto.displayStart", displayStart, 15);
        chk("auto.displayBank", displayBank, 0);
      end
    end
    if (!done) timeout_fail("auto.frameReady");

    // no auto-trigger when disabled
    do_reset(); tick();
    frCount = 0;
    for (int k = 0; k < 1000; k++) begin
      sampleValid = 1'b1; sampleData = 12'd100;
      tick();
      if (frameReady) frCount++;
    end
    chk("noauto.frames", frCount, 0);
    chk("noauto.state", captureState, 2);

    // decimation stride latched at PRE entry
    do_reset(); sampleAdjust = 6'd3; tick();
    lastW = -1;
    for (int k = 0; k < 40; k++) begin
      if (k == 10) sampleAdjust = 6'd0;
      sampleValid = 1'b1; sampleData = 12'(k);
      tick();
      if (wrEn) begin
        if (lastW >= 0) chk($sformatf("adj.gap@%0d", k), k - lastW, 4);
        lastW = k;
      end
    end

    // hold blocks the swap, then the next frame swaps
    do_reset(); autoEn = 1'b1; tick();
    hold = 1'b1; done = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      sampleValid = 1'b1; sampleData = 12'd100;
      tick();
      if (captureState == 3'd4) done = 1;
    end
    if (!done) timeout_fail("hold.reachSwap");
    tick();
    chk("hold.state", captureState, 0);
    chk("hold.frameReady", frameReady, 0);
    chk("hold.displayBank", displayBank, 1);
    hold = 1'b0;
    tick();
    chk("hold.resumePre", captureState, 1);
    done = 0; seenPost = 0;
    for (int k = 0; k < 200 && !done; k++) begin
      tick();
      if (wrEn && !seenPost) begin
        seenPost = 1; chk("hold.writeBank", wrAddr[4], 0);
      end
      if (frameReady) begin
        done = 1; chk("hold.newDisplayBank", displayBank, 0);
      end
    end
    if (!done) timeout_fail("hold.frameReady");

    // reset in the middle of POST
    do_reset(); tick();
    done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      sampleValid = 1'b1; sampleData = 12'((k * 256) % 4096);
      tick();
      if (captureState == 3'd3) done = 1;
    end
    if (!done) timeout_fail("midrst.reachPost");
    reset = 1'b1;
    tick();
    chk("midrst.state", captureState, 0);
    chk("midrst.wrEn", wrEn, 0);
    chk("midrst.wrAddr", wrAddr, 0);
    chk("midrst.wrData", wrData, 0);
    chk("midrst.displayBank", displayBank, 1);
    chk("midrst.displayStart", displayStart, 0);
    chk("midrst.frameReady", frameReady, 0);
    chk("midrst.autoTrig", autoTrig, 0);
    reset = 1'b0; sampleValid = 1'b0;
    frCount = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (frameReady) frCount++;
    end
    chk("midrst.noFrame", frCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wave_capture_ctrl.md
Name: wave_capture_ctrl

Overview:
- Capture sequencer between the ADC sample stream and the ping-pong wave sample RAM read by the display pipeline.
- Decimates the incoming samples by the time/div setting (sampleAdjust) and detects a level-crossing trigger, with an auto-trigger timeout.
- Writes one pre/post-trigger frame into the back bank, then swaps banks unless the wave is frozen by hold.
- One instance per wave channel.

Parameters:
- ADDR_W, 9: address bits per bank; DEPTH = 2^ADDR_W samples.
- DATA_W, 12: ADC sample width.
- PRETRIG, 64: samples kept before the trigger point; legal range 1 to DEPTH-2.
- AUTO_TIMEOUT, 2048: decimated samples in ARMED before a forced trigger.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sampleValid  in  1  one-cycle strobe, one ADC sample.
- sampleData  in  DATA_W  ADC sample, unsigned.
- sampleAdjust  in  6  time/div: keep 1 of every sampleAdjust+1 valid samples.
- hold  in  1  freeze the displayed frame.
- triggerLevel  in  DATA_W  trigger threshold, unsigned.
- triggerFalling  in  1  0 = rising-edge trigger, 1 = falling-edge trigger.
- autoEn  in  1  enable auto-trigger timeout.
- wrEn  out  1  RAM write strobe.
- wrAddr  out  ADDR_W+1  {writeBank, pointer}.
- wrData  out  DATA_W  RAM write data.
- displayBank  out  1  bank the display must read.
- displayStart  out  ADDR_W  address of the oldest sample of the displayed frame.
- frameReady  out  1  one-cycle pulse on a bank swap.
- autoTrig  out  1  displayed frame was force-triggered.
- captureState  out  3  state encoding, for debug LEDs.

Behaviour:
- Reset values:
  - State IDLE; all counters 0.
  - wrEn = 0, wrAddr = 0, wrData = 0.
  - writeBank = 0, displayBank = 1, displayStart = 0.
  - frameReady = 0, autoTrig = 0.
- Reset mid-frame discards the partial frame; no frameReady is issued.
- Decimation:
  - decCnt decrements on each sampleValid.
  - A sample is accepted when sampleValid=1 and decCnt=0; decCnt then reloads with adjLatched.
  - adjLatched captures sampleAdjust on entry to PRE and is constant for the whole frame.
- Write path:
  - Every accepted sample in PRE, ARMED or POST produces wrEn=1 on the next cycle, with wrData equal to the accepted sample and wrAddr = {writeBank, ptr}.
  - ptr then increments, wrapping DEPTH-1 to 0.
  - Latency is 1 cycle; wrEn is never high for two consecutive cycles unless sampleValid is.
- Trigger is evaluated only in ARMED, on accepted samples, against prev, the previous accepted sample.
  - Rising: prev < level and cur >= level.
  - Falling: prev > level and cur <= level.
  - prevOk clears on entry to PRE; no trigger fires until one sample has been accepted in the frame.
- States:
  - IDLE: no writes. Exits to PRE when hold=0, ptr=0, decCnt=0.
  - PRE: counts accepted samples. After PRETRIG accepted, go to ARMED; toCnt=0.
  - ARMED:
    - Each accepted sample is written and increments toCnt.
    - On a trigger, or (autoEn and toCnt reaching AUTO_TIMEOUT-1 on an accepted sample), go to POST.
    - Latch trigPtr = ptr of that sample, and autoFlag = 1 only if the transition came from the timeout alone.
    - A trigger and a timeout on the same sample count as a real trigger (autoFlag = 0).
    - The trigger sample is written and counted as post sample 0.
  - POST: after post count reaches DEPTH-PRETRIG-1 further accepted samples, go to SWAP.
  - SWAP, 1 cycle:
    - hold=0: displayBank <= writeBank, writeBank <= ~writeBank, displayStart <= (trigPtr - PRETRIG) mod DEPTH, autoTrig <= autoFlag, frameReady=1. Next state PRE; ptr=0.
    - hold=1: no swap, no pulse. Next state IDLE.
- Hold asserted during PRE, ARMED or POST does not abort the capture; it only gates the swap.
- Encoding: IDLE=0, PRE=1, ARMED=2, POST=3, SWAP=4.
- Arithmetic:
  - ptr and displayStart are modulo DEPTH.
  - toCnt saturates at AUTO_TIMEOUT-1 when autoEn=0.

Test Plan:
(Bench uses ADDR_W=4, PRETRIG=4, AUTO_TIMEOUT=32.)
- Reset, then sampleValid every cycle with a 0..4095 ramp step 256, level 2000, rising, adj 0:
  - ARMED after 4 writes.
  - Trigger on the sample equal to 2048.
  - 11 further writes, then frameReady pulse.
  - displayBank=0, displayStart = trigPtr-4 mod 16.
- Constant data 100, level 2000, autoEn=1 → frameReady after 4+32+11 accepted samples, autoTrig=1. With autoEn=0 → no frameReady after 1000 samples.
- adj=3 with sampleValid every cycle → wrEn every 4th cycle. Changing adj to 0 mid-frame → stride stays 4 until the next PRE.
- hold=1 before SWAP → no swap, state IDLE, displayBank unchanged. Drop hold → PRE, next frame swaps to the other bank.
- Reset pulse during POST → all outputs at their reset values next cycle, no frameReady.
- Falling mode, samples 3000, 1500 with level 2000 → trigger on 1500. Samples 2000, 2000 → no trigger.
